// File: rtl/sym_stream_sep.sv
// Signal/payload stream separator for the OFDM receive chain.
// Splits each frame into SIGNAL and PAYLOAD streams with symbol markers.
module sym_stream_sep #(
  parameter int DW           = 12,
  parameter int SYM_LEN      = 64,
  parameter int SIG_SYMS     = 1,
  parameter int MAX_PLD_SYMS = 6,
  parameter int SW           = $clog2(MAX_PLD_SYMS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  input  logic          din_vld,
  input  logic [SW-1:0] pld_syms,
  output logic [DW-1:0] dout_sig_re,
  output logic [DW-1:0] dout_sig_im,
  output logic          dout_sig_vld,
  output logic          dout_sig_last,
  output logic [DW-1:0] dout_pld_re,
  output logic [DW-1:0] dout_pld_im,
  output logic          dout_pld_vld,
  output logic          dout_pld_last,
  output logic [SW-1:0] dout_pld_sym,
  output logic          frame_done,
  output logic          err_trunc,
  output logic          err_ovf
);

  localparam int CW = $clog2(SYM_LEN);
  localparam int MS = (SIG_SYMS > MAX_PLD_SYMS) ?
                      SIG_SYMS : MAX_PLD_SYMS;
  localparam int YW = $clog2(MS + 1);

  localparam logic [CW-1:0] LAST_SAMP = CW'(SYM_LEN - 1);
  localparam logic [YW-1:0] SIG_LAST  = YW'(SIG_SYMS - 1);
  localparam logic [SW-1:0] MAX_N     = SW'(MAX_PLD_SYMS);

  typedef enum logic [1:0] {
    IDLE,
    SIG,
    PLD,
    DROP
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic [CW-1:0] r_samp;
  logic [CW-1:0] w_samp;
  logic [YW-1:0] r_sym;
  logic [YW-1:0] w_sym;
  logic [SW-1:0] r_pld_n;
  logic [SW-1:0] w_pld_n;
  logic          r_fresh;
  logic          r_ovf_seen;
  logic          w_ovf_seen;

  logic [DW-1:0] r_sig_re;
  logic [DW-1:0] r_sig_im;
  logic          r_sig_vld;
  logic          r_sig_last;
  logic [DW-1:0] r_pld_re;
  logic [DW-1:0] r_pld_im;
  logic          r_pld_vld;
  logic          r_pld_last;
  logic [SW-1:0] r_pld_sym;
  logic          r_done;
  logic          r_trunc;
  logic          r_ovf;

  logic [DW-1:0] w_sig_re;
  logic [DW-1:0] w_sig_im;
  logic          w_sig_vld;
  logic          w_sig_last;
  logic [DW-1:0] w_pld_re;
  logic [DW-1:0] w_pld_im;
  logic          w_pld_vld;
  logic          w_pld_last;
  logic [SW-1:0] w_pld_sym;
  logic          w_done;
  logic          w_trunc;
  logic          w_ovf;

  logic          w_eos;
  logic          w_sig_end;
  logic          w_pld_end;
  logic [SW-1:0] w_clamp;

  assign w_eos     = (r_samp == LAST_SAMP);
  assign w_sig_end = w_eos && (r_sym == SIG_LAST);
  assign w_pld_end = w_eos &&
                     (r_sym == YW'(r_pld_n) - YW'(1));
  assign w_clamp   = (pld_syms > MAX_N) ? MAX_N : pld_syms;

  always_comb begin
    w_state    = r_state;
    w_samp     = r_samp;
    w_sym      = r_sym;
    w_pld_n    = r_pld_n;
    w_ovf_seen = r_ovf_seen;
    w_sig_re   = '0;
    w_sig_im   = '0;
    w_sig_vld  = 1'b0;
    w_sig_last = 1'b0;
    w_pld_re   = '0;
    w_pld_im   = '0;
    w_pld_vld  = 1'b0;
    w_pld_last = 1'b0;
    w_pld_sym  = '0;
    w_done     = 1'b0;
    w_trunc    = 1'b0;
    w_ovf      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (din_vld) begin
          // A run already in progress at reset release is not a frame.
          if (r_fresh) begin
            w_state    = DROP;
            w_ovf_seen = 1'b1;
          end else begin
            w_pld_n   = w_clamp;
            w_sig_vld = 1'b1;
            w_sig_re  = din_re;
            w_sig_im  = din_im;
            w_samp    = CW'(1);
            w_sym     = '0;
            w_state   = SIG;
          end
        end
      end
      SIG: begin
        if (!din_vld) begin
          w_trunc = 1'b1;
          w_samp  = '0;
          w_sym   = '0;
          w_state = IDLE;
        end else begin
          w_sig_vld  = 1'b1;
          w_sig_re   = din_re;
          w_sig_im   = din_im;
          w_sig_last = w_eos;
          if (w_eos) begin
            w_samp = '0;
            if (w_sig_end) begin
              w_sym = '0;
              if (r_pld_n != '0) begin
                w_state = PLD;
              end else begin
                w_done     = 1'b1;
                w_ovf_seen = 1'b0;
                w_state    = DROP;
              end
            end else begin
              w_sym = r_sym + YW'(1);
            end
          end else begin
            w_samp = r_samp + CW'(1);
          end
        end
      end
      PLD: begin
        if (!din_vld) begin
          w_trunc = 1'b1;
          w_samp  = '0;
          w_sym   = '0;
          w_state = IDLE;
        end else begin
          w_pld_vld  = 1'b1;
          w_pld_re   = din_re;
          w_pld_im   = din_im;
          w_pld_last = w_eos;
          w_pld_sym  = SW'(r_sym);
          if (w_eos) begin
            w_samp = '0;
            if (w_pld_end) begin
              w_sym      = '0;
              w_done     = 1'b1;
              w_ovf_seen = 1'b0;
              w_state    = DROP;
            end else begin
              w_sym = r_sym + YW'(1);
            end
          end else begin
            w_samp = r_samp + CW'(1);
          end
        end
      end
      DROP: begin
        if (!din_vld) begin
          w_state = IDLE;
        end else if (!r_ovf_seen) begin
          w_ovf      = 1'b1;
          w_ovf_seen = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_samp     <= '0;
      r_sym      <= '0;
      r_pld_n    <= '0;
      r_fresh    <= 1'b1;
      r_ovf_seen <= 1'b0;
      r_sig_re   <= '0;
      r_sig_im   <= '0;
      r_sig_vld  <= 1'b0;
      r_sig_last <= 1'b0;
      r_pld_re   <= '0;
      r_pld_im   <= '0;
      r_pld_vld  <= 1'b0;
      r_pld_last <= 1'b0;
      r_pld_sym  <= '0;
      r_done     <= 1'b0;
      r_trunc    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_samp     <= w_samp;
      r_sym      <= w_sym;
      r_pld_n    <= w_pld_n;
      r_fresh    <= 1'b0;
      r_ovf_seen <= w_ovf_seen;
      r_sig_re   <= w_sig_re;
      r_sig_im   <= w_sig_im;
      r_sig_vld  <= w_sig_vld;
      r_sig_last <= w_sig_last;
      r_pld_re   <= w_pld_re;
      r_pld_im   <= w_pld_im;
      r_pld_vld  <= w_pld_vld;
      r_pld_last <= w_pld_last;
      r_pld_sym  <= w_pld_sym;
      r_done     <= w_done;
      r_trunc    <= w_trunc;
      r_ovf      <= w_ovf;
    end
  end

  assign dout_sig_re   = r_sig_re;
  assign dout_sig_im   = r_sig_im;
  assign dout_sig_vld  = r_sig_vld;
  assign dout_sig_last = r_sig_last;
  assign dout_pld_re   = r_pld_re;
  assign dout_pld_im   = r_pld_im;
  assign dout_pld_vld  = r_pld_vld;
  assign dout_pld_last = r_pld_last;
  assign dout_pld_sym  = r_pld_sym;
  assign frame_done    = r_done;
  assign err_trunc     = r_trunc;
  assign err_ovf       = r_ovf;

endmodule

// File: tb/tb_sym_stream_sep.sv
// Randomised bench for sym_stream_sep against a frame-level model.
// Output of input sample k is compared right after its clock edge.
module tb_sym_stream_sep;

  localparam int DW   = 12;
  localparam int SL   = 64;
  localparam int SIGS = 1;
  localparam int MAXP = 6;
  localparam int SW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_re;
  logic [DW-1:0] din_im;
  logic          din_vld;
  logic [SW-1:0] pld_syms;
  logic [DW-1:0] dout_sig_re;
  logic [DW-1:0] dout_sig_im;
  logic          dout_sig_vld;
  logic          dout_sig_last;
  logic [DW-1:0] dout_pld_re;
  logic [DW-1:0] dout_pld_im;
  logic          dout_pld_vld;
  logic          dout_pld_last;
  logic [SW-1:0] dout_pld_sym;
  logic          frame_done;
  logic          err_trunc;
  logic          err_ovf;

  sym_stream_sep dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_re       (din_re),
    .din_im       (din_im),
    .din_vld      (din_vld),
    .pld_syms     (pld_syms),
    .dout_sig_re  (dout_sig_re),
    .dout_sig_im  (dout_sig_im),
    .dout_sig_vld (dout_sig_vld),
    .dout_sig_last(dout_sig_last),
    .dout_pld_re  (dout_pld_re),
    .dout_pld_im  (dout_pld_im),
    .dout_pld_vld (dout_pld_vld),
    .dout_pld_last(dout_pld_last),
    .dout_pld_sym (dout_pld_sym),
    .frame_done   (frame_done),
    .err_trunc    (err_trunc),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] sre;
    logic [DW-1:0] sim;
    logic          sv;
    logic          sl;
    logic [DW-1:0] pre;
    logic [DW-1:0] pim;
    logic          pv;
    logic          pl;
    logic [SW-1:0] psym;
    logic          fd;
    logic          et;
    logic          eo;
  } out_t;

  out_t obs;
  assign obs = {dout_sig_re, dout_sig_im, dout_sig_vld,
                dout_sig_last, dout_pld_re, dout_pld_im,
                dout_pld_vld, dout_pld_last, dout_pld_sym,
                frame_done, err_trunc, err_ovf};

  int errors = 0;
  int checks = 0;
  int n_sig, n_pld, n_sl, n_pl, n_fd, n_et, n_eo;

  // Frame-level expectation for input index k of a run of L samples.
  function automatic out_t model(input int k, input int L,
                                 input int n,
                                 input logic [DW-1:0] re,
                                 input logic [DW-1:0] im);
    out_t e;
    int   total;
    int   ns;
    e     = '0;
    ns    = SIGS * SL;
    total = SL * (SIGS + n);
    if (k < L) begin
      if (k < total) begin
        if (k < ns) begin
          e.sv  = 1'b1;
          e.sre = re;
          e.sim = im;
          e.sl  = ((k % SL) == SL - 1);
        end else begin
          e.pv   = 1'b1;
          e.pre  = re;
          e.pim  = im;
          e.pl   = ((k % SL) == SL - 1);
          e.psym = SW'((k - ns) / SL);
        end
        e.fd = (k == total - 1);
      end else begin
        e.eo = (k == total);
      end
    end else if (k == L && L < total) begin
      e.et = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic v,
                      input logic [DW-1:0] re,
                      input logic [DW-1:0] im,
                      input logic [SW-1:0] p,
                      output out_t o);
    @(negedge clk);
    din_vld  = v;
    din_re   = re;
    din_im   = im;
    pld_syms = p;
    @(posedge clk);
    #1;
    o = obs;
  endtask

  task automatic run_frame(input int L, input int p,
                           input int gap, input string tag);
    out_t          got;
    out_t          exp;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [SW-1:0] ps;
    int            n;
    n = (p > MAXP) ? MAXP : p;
    n_sig = 0; n_pld = 0; n_sl = 0; n_pl = 0;
    n_fd = 0; n_et = 0; n_eo = 0;
    for (int k = 0; k < L + gap; k++) begin
      re = DW'($urandom);
      im = DW'($urandom);
      ps = (k == 0) ? SW'(p) : SW'($urandom);
      step(k < L, re, im, ps, got);
      exp = model(k, L, n, re, im);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got=%h required=%h",
                 tag, k, got, exp);
      end
      n_sig += int'(got.sv);
      n_pld += int'(got.pv);
      n_sl  += int'(got.sl);
      n_pl  += int'(got.pl);
      n_fd  += int'(got.fd);
      n_et  += int'(got.et);
      n_eo  += int'(got.eo);
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    din_vld  = 1'b0;
    din_re   = '0;
    din_im   = '0;
    pld_syms = '0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h required=0", obs);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_release got=%h required=0", obs);
    end
  endtask

  task automatic test_nominal;
    run_frame(448, 6, 2, "nominal");
    checks++;
    if (n_sig != 64 || n_pld != 384 || n_sl != 1 ||
        n_pl != 6 || n_fd != 1 || n_et != 0 || n_eo != 0) begin
      errors++;
      $display("FAIL nominal_counts got=%0d/%0d/%0d/%0d/%0d required=64/384/1/6/1",
               n_sig, n_pld, n_sl, n_pl, n_fd);
    end
  endtask

  task automatic test_sig_only;
    run_frame(80, 0, 1, "sig_only");
    checks++;
    if (n_sig != 64 || n_pld != 0 || n_fd != 1 || n_eo != 1) begin
      errors++;
      $display("FAIL sig_only_counts got=%0d/%0d/%0d/%0d required=64/0/1/1",
               n_sig, n_pld, n_fd, n_eo);
    end
  endtask

  task automatic test_clamp;
    run_frame(448, 7, 1, "clamp");
    checks++;
    if (n_pld != 384 || n_fd != 1 || n_eo != 0) begin
      errors++;
      $display("FAIL clamp_counts got=%0d/%0d/%0d required=384/1/0",
               n_pld, n_fd, n_eo);
    end
  endtask

  task automatic test_trunc;
    run_frame(200, 6, 1, "trunc");
    checks++;
    if (n_sig != 64 || n_pld != 136 || n_et != 1 || n_fd != 0) begin
      errors++;
      $display("FAIL trunc_counts got=%0d/%0d/%0d/%0d required=64/136/1/0",
               n_sig, n_pld, n_et, n_fd);
    end
    run_frame(64, 0, 1, "after_trunc");
    checks++;
    if (n_sig != 64 || n_fd != 1 || n_et != 0) begin
      errors++;
      $display("FAIL after_trunc_counts got=%0d/%0d/%0d required=64/1/0",
               n_sig, n_fd, n_et);
    end
  endtask

  task automatic test_overlong;
    run_frame(460, 6, 1, "overlong");
    checks++;
    if (n_pld != 384 || n_fd != 1 || n_eo != 1) begin
      errors++;
      $display("FAIL overlong_counts got=%0d/%0d/%0d required=384/1/1",
               n_pld, n_fd, n_eo);
    end
  endtask

  task automatic test_back_to_back;
    int fd_total;
    run_frame(448, 6, 1, "b2b_a");
    fd_total = n_fd;
    run_frame(448, 6, 1, "b2b_b");
    fd_total += n_fd;
    checks++;
    if (fd_total != 2 || n_pld != 384) begin
      errors++;
      $display("FAIL b2b_counts got=%0d/%0d required=2/384",
               fd_total, n_pld);
    end
  endtask

  task automatic test_reset_midframe;
    out_t          got;
    out_t          exp;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    for (int k = 0; k < 100; k++) begin
      re = DW'($urandom);
      im = DW'($urandom);
      step(1'b1, re, im, (k == 0) ? 3'd6 : 3'd2, got);
      exp = model(k, 1000, 6, re, im);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_pre k=%0d got=%h required=%h",
                 k, got, exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL rst_async got=%h required=0", obs);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, DW'($urandom), DW'($urandom), 3'd6, got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, DW'($urandom), DW'($urandom), 3'd6, got);
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL rst_drop k=%0d got=%h required=0",
                 k, got);
      end
    end
    step(1'b0, '0, '0, 3'd6, got);
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL rst_gap got=%h required=0", got);
    end
    run_frame(448, 6, 1, "rst_next");
    checks++;
    if (n_fd != 1 || n_sig != 64 || n_pld != 384) begin
      errors++;
      $display("FAIL rst_next_counts got=%0d/%0d/%0d required=1/64/384",
               n_fd, n_sig, n_pld);
    end
  endtask

  task automatic test_random;
    int L;
    int p;
    int g;
    int n;
    int total;
    for (int f = 0; f < 8; f++) begin
      L = $urandom_range(1, 500);
      p = $urandom_range(0, 7);
      g = $urandom_range(1, 3);
      n = (p > MAXP) ? MAXP : p;
      total = SL * (SIGS + n);
      run_frame(L, p, g, "random");
      checks++;
      if (n_fd != ((L >= total) ? 1 : 0) ||
          n_et != ((L < total) ? 1 : 0) ||
          n_eo != ((L > total) ? 1 : 0)) begin
        errors++;
        $display("FAIL random_flags L=%0d p=%0d got=%0d/%0d/%0d",
                 L, p, n_fd, n_et, n_eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sig_only();
    test_clamp();
    test_trunc();
    test_overlong();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
